// File: rtl/br_pkg.sv
// br_pkg: shared sizes and state encoding for the register-bank sequencer.
// Revision: 1.0
`default_nettype none

package br_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DUMP   = 2'd3
  } br_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/br_seq_idx.sv
// br_seq_idx: 5-bit register index with clear/increment and a terminal flag.
// Revision: 1.0
`default_nettype none

module br_seq_idx
  import br_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_half,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // VERIFY walks register pairs, so it terminates half way through the index range.
  assign o_idx  = r_idx;
  assign o_last = i_half ? (r_idx == 5'd15) : (r_idx == 5'd31);

endmodule

`default_nettype wire

// File: rtl/br_seq.sv
// br_seq: fills or dumps the BR register bank for bring-up/debug.
// Optional read-back check enabled by macro BR_SEQ_VERIFY_EN. Revision: 1.0
`default_nettype none

module br_seq
  import br_pkg::*;
#(
  parameter int          NREGS     = 32,
  parameter logic [31:0] FILL_BASE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  input  logic              dump_start,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic              we,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic [ADDR_W-1:0] a3,
  output logic [31:0]       wd3,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data
);

  br_seq_state_t     r_state;
  br_seq_state_t     w_next;
  logic              r_done;
  logic              w_clr, w_inc, w_done_set, w_err_clr, w_err_set, w_last;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_even, w_odd;

  br_seq_idx u_idx (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .i_half (r_state == ST_VERIFY),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  assign w_even = {w_idx[3:0], 1'b0};
  assign w_odd  = {w_idx[3:0], 1'b1};

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_inc      = 1'b0;
    w_done_set = 1'b0;
    w_err_clr  = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_start) begin
          w_next    = ST_INIT;
          w_clr     = 1'b1;
          w_err_clr = 1'b1;
        end else if (dump_start) begin
          w_next = ST_DUMP;
          w_clr  = 1'b1;
        end
      end
      ST_INIT: begin
        w_inc = 1'b1;
        if (w_last) begin
          w_clr = 1'b1;
`ifdef BR_SEQ_VERIFY_EN
          w_next = ST_VERIFY;
`else
          w_next     = ST_IDLE;
          w_done_set = 1'b1;
`endif
        end
      end
      ST_VERIFY: begin
        w_inc     = 1'b1;
        w_err_set = (rd1 != FILL_BASE + 32'(w_even)) || (rd2 != FILL_BASE + 32'(w_odd));
        if (w_last) begin
          w_clr      = 1'b1;
          w_next     = ST_IDLE;
          w_done_set = 1'b1;
        end
      end
      ST_DUMP: begin
        if (out_ready) begin
          w_inc = 1'b1;
          if (w_last) begin
            w_clr      = 1'b1;
            w_next     = ST_IDLE;
            w_done_set = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
    end
  end

`ifdef BR_SEQ_VERIFY_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst || w_err_clr) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end
  assign verify_err = r_err;
  assign a2         = (r_state == ST_VERIFY) ? w_odd : '0;
`else
  logic w_unused_verify;
  assign w_unused_verify = ^rd2 ^ w_err_clr ^ w_err_set;
  assign verify_err      = 1'b0;
  assign a2              = '0;
`endif

  // Gating with rst keeps the bank from taking the write of the cycle in which reset lands.
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign we        = (r_state == ST_INIT) && !rst;
  assign a3        = (r_state == ST_INIT) ? w_idx : '0;
  assign wd3       = (r_state == ST_INIT) ? FILL_BASE + 32'(w_idx) : 32'h0;
  assign a1        = (r_state == ST_VERIFY) ? w_even :
                     (r_state == ST_DUMP)   ? w_idx  : '0;
  assign out_valid = (r_state == ST_DUMP);
  assign out_addr  = (r_state == ST_DUMP) ? w_idx : '0;
  assign out_data  = (r_state == ST_DUMP) ? rd1 : 32'h0;

endmodule

`default_nettype wire
